// File: rtl/pwm_leg_deadtime.sv
// Half-bridge PWM leg: double-buffered duty compare against a triangle carrier
// with programmable dead time between complementary gates.
module pwm_leg_deadtime #(
   parameter int WIDTH       = 16,
   parameter bit UPDATE_MODE = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             enable,
   input  logic [WIDTH-1:0] carrier,
   input  logic [WIDTH-1:0] carrier_max,
   input  logic [WIDTH-1:0] duty,
   input  logic             duty_wr,
   input  logic [7:0]       deadtime,
   output logic             gate_hi,
   output logic             gate_lo,
   output logic [WIDTH-1:0] duty_active,
   output logic             pending_valid,
   output logic             evt_peak,
   output logic             evt_valley
);

   typedef enum logic [2:0] {
      OFF,
      DT_HI,
      HI_ON,
      DT_LO,
      LO_ON
   } state_t;

   state_t           state;
   logic [7:0]       dt_cnt;
   logic [WIDTH-1:0] carrier_q;
   logic [WIDTH-1:0] pending;
   logic             raw_q;
   logic             load;

   // Events fire only on the first clock of a dwell at an extreme.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         carrier_q  <= '0;
         evt_peak   <= 1'b0;
         evt_valley <= 1'b0;
      end else begin
         carrier_q  <= carrier;
         evt_peak   <= (carrier == carrier_max) && (carrier_q != carrier_max);
         evt_valley <= (carrier == '0) && (carrier_q != '0);
      end
   end

   assign load = pending_valid &&
                 (evt_valley || (UPDATE_MODE && evt_peak));

   // A write coinciding with a load re-arms pending after the old value moves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending       <= '0;
         pending_valid <= 1'b0;
         duty_active   <= '0;
         raw_q         <= 1'b0;
      end else begin
         if (load) begin
            duty_active   <= pending;
            pending_valid <= 1'b0;
         end
         if (duty_wr) begin
            pending       <= duty;
            pending_valid <= 1'b1;
         end
         raw_q <= carrier < duty_active;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= OFF;
         dt_cnt  <= 8'd0;
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
      end else begin
         gate_hi <= 1'b0;
         gate_lo <= 1'b0;
         if (!enable) begin
            state <= OFF;
         end else begin
            unique case (state)
               OFF: begin
                  state  <= raw_q ? DT_HI : DT_LO;
                  dt_cnt <= deadtime;
               end
               DT_HI: begin
                  if (!raw_q) begin
                     state  <= DT_LO;
                     dt_cnt <= deadtime;
                  end else if (dt_cnt != 8'd0) begin
                     dt_cnt <= dt_cnt - 8'd1;
                  end else begin
                     state   <= HI_ON;
                     gate_hi <= 1'b1;
                  end
               end
               HI_ON: begin
                  if (!raw_q) begin
                     state  <= DT_LO;
                     dt_cnt <= deadtime;
                  end else begin
                     gate_hi <= 1'b1;
                  end
               end
               DT_LO: begin
                  if (raw_q) begin
                     state  <= DT_HI;
                     dt_cnt <= deadtime;
                  end else if (dt_cnt != 8'd0) begin
                     dt_cnt <= dt_cnt - 8'd1;
                  end else begin
                     state   <= LO_ON;
                     gate_lo <= 1'b1;
                  end
               end
               LO_ON: begin
                  if (raw_q) begin
                     state  <= DT_HI;
                     dt_cnt <= deadtime;
                  end else begin
                     gate_lo <= 1'b1;
                  end
               end
               default: state <= OFF;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_pwm_leg_deadtime.sv
// Randomized bench for pwm_leg_deadtime: two legs (valley-only and
// valley+peak update) checked every clock against a behavioural model.
module tb_pwm_leg_deadtime;

   logic        clk;
   logic        rst_n;
   logic        enable;
   logic [15:0] carrier;
   logic [15:0] carrier_max;
   logic [15:0] duty;
   logic        duty_wr;
   logic [7:0]  deadtime;
   logic [1:0]  gh, gl, pv, pk, vl;
   logic [15:0] da [2];

   pwm_leg_deadtime #(.WIDTH(16), .UPDATE_MODE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .carrier(carrier), .carrier_max(carrier_max),
      .duty(duty), .duty_wr(duty_wr), .deadtime(deadtime),
      .gate_hi(gh[0]), .gate_lo(gl[0]), .duty_active(da[0]),
      .pending_valid(pv[0]), .evt_peak(pk[0]), .evt_valley(vl[0])
   );

   pwm_leg_deadtime #(.WIDTH(16), .UPDATE_MODE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .carrier(carrier), .carrier_max(carrier_max),
      .duty(duty), .duty_wr(duty_wr), .deadtime(deadtime),
      .gate_hi(gh[1]), .gate_lo(gl[1]), .duty_active(da[1]),
      .pending_valid(pv[1]), .evt_peak(pk[1]), .evt_valley(vl[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state.
   logic [15:0] m_cq;
   logic        m_pk, m_vl;
   logic [15:0] m_da [2];
   logic [15:0] m_pd [2];
   logic        m_pv [2];
   logic        m_raw [2];
   int          m_tgt [2];
   int          m_lows [2];
   int          m_need [2];
   logic        m_on [2];

   // Stimulus state.
   int   c, hold, div;
   bit   up;
   int   mode;
   int   jit_base;
   bit   wr_req;
   logic [15:0] wr_val;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_cq = '0; m_pk = 0; m_vl = 0;
      for (int m = 0; m < 2; m++) begin
         m_da[m] = '0; m_pd[m] = '0; m_pv[m] = 0; m_raw[m] = 0;
         m_tgt[m] = 0; m_lows[m] = 0; m_need[m] = 0; m_on[m] = 0;
      end
   endtask

   // Gate rule: any change of wanted side starts a fresh low interval
   // of deadtime+1 clocks; the wanted side turns on once it has elapsed.
   task automatic model_step();
      int  want;
      bit  ld;
      for (int m = 0; m < 2; m++) begin
         want = m_raw[m] ? 1 : 2;
         if (!enable) begin
            m_tgt[m] = 0;
            m_on[m]  = 0;
         end else if (m_tgt[m] == 0 || want != m_tgt[m]) begin
            m_tgt[m]  = want;
            m_lows[m] = 1;
            m_need[m] = int'(deadtime) + 1;
            m_on[m]   = 0;
         end else if (!m_on[m]) begin
            if (m_lows[m] < m_need[m]) m_lows[m]++;
            else m_on[m] = 1;
         end
         ld = m_pv[m] && (m_vl || (m == 1 && m_pk));
         m_raw[m] = carrier < m_da[m];
         if (ld) begin
            m_da[m] = m_pd[m];
            m_pv[m] = 0;
         end
         if (duty_wr) begin
            m_pd[m] = duty;
            m_pv[m] = 1;
         end
      end
      m_pk = (carrier == carrier_max) && (m_cq != carrier_max);
      m_vl = (carrier == 16'd0) && (m_cq != 16'd0);
      m_cq = carrier;
   endtask

   task automatic compare_all();
      for (int m = 0; m < 2; m++) begin
         check($sformatf("gate_hi%0d", m), 32'(gh[m]),
               32'(m_on[m] && m_tgt[m] == 1));
         check($sformatf("gate_lo%0d", m), 32'(gl[m]),
               32'(m_on[m] && m_tgt[m] == 2));
         check($sformatf("both_on%0d", m), 32'(gh[m] & gl[m]), 32'd0);
         check($sformatf("duty_act%0d", m), 32'(da[m]), 32'(m_da[m]));
         check($sformatf("pend_v%0d", m), 32'(pv[m]), 32'(m_pv[m]));
         check($sformatf("evt_pk%0d", m), 32'(pk[m]), 32'(m_pk));
         check($sformatf("evt_vl%0d", m), 32'(vl[m]), 32'(m_vl));
      end
   endtask

   // Entered and left at a falling edge.
   task automatic do_reset();
      #3 rst_n = 1'b0;
      #1 model_reset();
      compare_all();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic step_carrier();
      if (hold < div) begin
         hold++;
      end else begin
         hold = 0;
         if (up) begin
            if (c >= int'(carrier_max)) begin
               up = 0;
               if (c > 0) c--;
            end else begin
               c++;
            end
         end else begin
            if (c == 0) begin
               up = 1;
               c++;
            end else begin
               c--;
            end
         end
      end
   endtask

   task automatic cycle();
      duty_wr = 1'b0;
      if (mode == 1) begin
         if ($urandom_range(0, 39) == 0) begin
            wr_req = 1;
            wr_val = 16'($urandom_range(0, int'(carrier_max) + 2));
         end
         if ($urandom_range(0, 49) == 0) deadtime = 8'($urandom_range(0, 12));
         if ($urandom_range(0, 199) == 0) enable = ~enable;
         if ($urandom_range(0, 299) == 0)
            carrier_max = 16'($urandom_range(20, 120));
      end
      if (wr_req) begin
         duty    = wr_val;
         duty_wr = 1'b1;
         wr_req  = 0;
      end
      if (mode == 2) begin
         carrier = 16'(jit_base + int'($urandom_range(0, 6)) - 3);
      end else begin
         step_carrier();
         carrier = 16'(c);
      end
      @(posedge clk);
      #1 model_step();
      compare_all();
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic write(input logic [15:0] v);
      wr_req = 1;
      wr_val = v;
   endtask

   task automatic wait_evt(input bit peak);
      int k;
      k = 0;
      while (!(peak ? m_pk : m_vl) && k < 3000) begin
         cycle();
         k++;
      end
      check(peak ? "wait_peak" : "wait_valley", 32'(k < 3000), 32'd1);
   endtask

   task automatic wait_side(input int side);
      int k;
      k = 0;
      while (!(m_on[0] && m_tgt[0] == side) && k < 3000) begin
         cycle();
         k++;
      end
      check("wait_side", 32'(k < 3000), 32'd1);
   endtask

   logic [15:0] saved;

   initial begin
      rst_n = 1'b0; enable = 1'b0; carrier = '0; carrier_max = 16'd100;
      duty = '0; duty_wr = 1'b0; deadtime = 8'd5;
      c = 0; hold = 0; div = 0; up = 1; mode = 0; jit_base = 50;
      wr_req = 0; wr_val = '0;
      model_reset();
      @(negedge clk);
      do_reset();

      // Basic switching, duty 50, deadtime 5.
      enable = 1'b1;
      write(16'd50);
      run(450);
      check("p1_duty", 32'(da[0]), 32'd50);

      // Two writes in one period: last wins at the valley.
      wait_evt(0);
      run(20);
      write(16'd30);
      run(30);
      write(16'd70);
      wait_evt(1);
      run(2);
      check("p2_hold", 32'(da[0]), 32'd50);
      wait_evt(0);
      run(2);
      check("p2_load", 32'(da[0]), 32'd70);

      // Slow carrier, write just after valley; mode-1 leg loads at peak.
      div = 3;
      wait_evt(0);
      saved = da[0];
      write(16'd20);
      wait_evt(1);
      cycle();
      check("p3_peak1", 32'(da[1]), 32'd20);
      check("p3_peak0", 32'(da[0]), 32'(saved));
      run(200);
      div = 0;

      // Compare extremes.
      write(16'd0);
      run(450);
      write(16'd101);
      run(450);

      // Zero dead time, then reversals inside a long dead time.
      deadtime = 8'd0;
      write(16'd50);
      run(450);
      deadtime = 8'd10;
      mode = 2;
      jit_base = 50;
      run(400);
      mode = 0;

      // Enable toggling and reset mid-period.
      deadtime = 8'd5;
      wait_side(1);
      enable = 1'b0;
      run(5);
      enable = 1'b1;
      run(300);
      do_reset();
      enable = 1'b1;
      write(16'd40);
      run(300);

      // Random soak.
      mode = 1;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 999) == 0) do_reset();
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_leg_deadtime.md
Name: pwm_leg_deadtime

Overview:
- Consumes the 16-bit triangle carrier from the inverter carrier generator and produces one complementary gate pair (high side, low side) for a single half-bridge leg.
- Double-buffers the duty command, latched into the active compare register only at carrier extremes, so each PWM period uses a glitch-free duty value.
- Inserts programmable dead time on every gate transition.
- Sits between the carrier generator and the inverter gate outputs; one instance per leg.

Parameters:
- WIDTH, 16, width of carrier, carrier_max and duty.
- UPDATE_MODE, 0, 0 = load pending duty at valley only; 1 = load at both valley and peak.

Ports:
- clk  in  1  system clock (50 MHz).
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  1 = leg switching; 0 = both gates forced low.
- carrier  in  WIDTH  triangle carrier, 0..carrier_max, each value held divider+1 clocks.
- carrier_max  in  WIDTH  carrier peak value.
- duty  in  WIDTH  duty command (compare level).
- duty_wr  in  1  1-clk strobe: capture duty into pending register.
- deadtime  in  8  dead time in clk cycles.
- gate_hi  out  1  high-side gate, registered.
- gate_lo  out  1  low-side gate, registered.
- duty_active  out  WIDTH  compare value currently in use.
- pending_valid  out  1  pending duty not yet loaded.
- evt_peak  out  1  1-clk pulse on the first clock carrier==carrier_max.
- evt_valley  out  1  1-clk pulse on the first clock carrier==0.

Behaviour:
- Reset values:
  - gate_hi=0, gate_lo=0.
  - duty_active=0, pending=0, pending_valid=0.
  - evt_peak=0, evt_valley=0.
  - FSM=OFF.
  - carrier_q=0, raw_q=0.
- Extreme detection:
  - carrier_q is a registered copy of carrier.
  - evt_peak=1 when carrier==carrier_max && carrier_q!=carrier_max, so it fires once per dwell.
  - evt_valley is the same rule with value 0.
  - Both events are registered (1-clk latency).
- Pending register:
  - duty_wr=1 sets pending<=duty and pending_valid<=1.
  - A later write before a load overwrites pending (last write wins).
- Load:
  - On the evt_valley cycle (and on evt_peak if UPDATE_MODE=1) with pending_valid=1: duty_active<=pending and pending_valid<=0.
  - If duty_wr coincides with a load cycle, the load takes the OLD pending value. The new value becomes pending with pending_valid=1.
- Compare: raw_q <= (carrier < duty_active), unsigned.
  - duty_active=0 gives gate_lo permanently on.
  - duty_active>carrier_max gives gate_hi permanently on.
- FSM states: OFF, DT_HI, HI_ON, DT_LO, LO_ON. Dead-time counter dt_cnt is 8 bits.
  - OFF: both low. When enable=1: go to DT_HI if raw_q=1, else DT_LO; load dt_cnt=deadtime.
  - DT_HI / DT_LO: both low.
    - dt_cnt!=0: decrement.
    - dt_cnt==0: go to HI_ON / LO_ON respectively.
  - HI_ON: gate_hi=1. When raw_q=0: go to DT_LO, dt_cnt=deadtime.
  - LO_ON: gate_lo=1. When raw_q=1: go to DT_HI, dt_cnt=deadtime.
  - raw_q reversal during a DT state: switch to the opposite DT state, reload dt_cnt=deadtime, both gates stay low.
  - enable=0 in any state: go to OFF next clock; gates low on that edge.
- Gate timing:
  - Gates decode directly from the registered state.
  - The active gate drops on the edge after raw_q changes.
  - Both gates are low for exactly deadtime+1 clocks (minimum 1, even with deadtime=0).
  - Then the opposite gate rises.
- Invariant: gate_hi && gate_lo is never 1, in any cycle, including reset and enable toggling.
- deadtime is sampled only when dt_cnt is loaded; changes mid-count have no effect until the next transition.
- Reset mid-operation: both gates drop immediately (asynchronous); all state returns to reset values.
- carrier_max change: takes effect on peak detection immediately; no other state is affected.

Test Plan:
1. Reset, enable=1, carrier ramp 0..100..0 (divider 0), duty_wr with duty=50, deadtime=5 -> duty_active=50 after the first evt_valley; gate_hi while carrier<50; each transition has exactly 6 both-low clocks; never both high.
2. duty_wr duty=30 then duty=70 mid-period, UPDATE_MODE=0 -> duty_active unchanged at the peak; becomes 70 at the next valley; pending_valid 1 until then, 0 after.
3. UPDATE_MODE=1, duty_wr duty=20 just after the valley -> loads at the next peak (carrier==100), duty_active=20; evt_peak exactly 1 clk wide with divider=3.
4. duty_active=0 -> gate_lo continuous, gate_hi 0; duty_active=101, carrier_max=100 -> gate_hi continuous after the initial 6-clk dead time.
5. deadtime=0, carrier crossing duty -> exactly 1 both-low clock per transition. Force raw_q reversal 2 clks into deadtime=10 -> opposite DT state, counter reloaded, 11 both-low clocks from the reversal.
6. Deassert enable while gate_hi=1 -> both low next clock; reassert -> dead time applied before any gate. Pulse rst_n low mid-period -> gates 0 asynchronously, duty_active=0, pending_valid=0.
